alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//   Sequences a shared 32-bit arithmetic unit (adder or multiplier) over a packet payload.
//   On a start pulse it pulls operand bytes from the UART RX byte stream and assembles them
//   into 32-bit little-endian words. It folds the words through the unit (acc = acc OP word)
//   and reports the final result with a done pulse.
//   Sits between the UART command state machine (start/len) and the arithmetic units.
// PARAMETERS
//   datawidth_p  8   RX byte width; fixed at 8 for this block (4 bytes per operand)
//   hdr_bytes_p  4   header bytes (opcode, reserved, len LSB, len MSB) counted in len_i
// PORTS
//   clk_i              in   1   clock; single clock domain
//   rst_ni             in   1   asynchronous, active-low reset
//   start_add_i        in   1   1-cycle pulse: begin add-reduction
//   start_mul_i        in   1   1-cycle pulse: begin mul-reduction
//   len_i              in   16  total packet length in bytes incl. header; sampled on start
//   rx_data_i          in   8   payload byte
//   rx_valid_i         in   1   payload byte valid
//   rx_ready_o         out  1   sequencer accepts byte
//   op_a_o             out  32  operand A to unit (accumulator)
//   op_b_o             out  32  operand B to unit (new word)
//   op_mul_o           out  1   1 = multiply, 0 = add
//   op_valid_o         out  1   operation request
//   op_ready_i         in   1   unit accepts request
//   op_result_i        in   32  unit result (low 32 bits)
//   op_result_valid_i  in   1   result valid, 1-cycle pulse
//   result_o           out  32  final accumulator; held until next accepted start
//   done_o             out  1   1-cycle pulse: result_o valid
//   busy_o             out  1   high from accepted start until done_o cycle inclusive
// BEHAVIOUR
//   - Reset (async assert, sync release): state=Idle. All outputs 0: rx_ready_o, op_*_o,
//     op_valid_o, result_o, done_o, busy_o. Reset mid-operation aborts; partial bytes dropped.
//   - Operand count N = (len_i - 4) >> 2, computed on start; len_i < 8 gives N=0.
//     len_i[1:0] remainder bytes are never consumed.
//   - States: Idle -> Gather -> (Issue -> WaitRes ->) Gather ... -> Done -> Idle.
//   - Idle: start accepted only here. start_add_i and start_mul_i together: add wins.
//     Latch op_mul, remaining=N, first=1, byte_cnt=0. N=0: go to Done with acc=0.
//     Otherwise go to Gather next cycle.
//   - Starts while busy_o=1 are ignored; no queueing.
//   - Gather: rx_ready_o=1. Byte accepted on rx_valid_i && rx_ready_o.
//     Byte k (0..3) is placed in word[8k+7:8k]. On the 4th byte: remaining decrements.
//     If first: acc<=word, first<=0, then Done if remaining==0 else stay in Gather.
//     If not first: go to Issue.
//   - Issue: rx_ready_o=0, op_valid_o=1, op_a_o=acc, op_b_o=word, op_mul_o=latched op.
//     All held stable until op_ready_i. On op_valid_o && op_ready_i: go to WaitRes,
//     op_valid_o=0 next cycle.
//   - WaitRes: on op_result_valid_i, acc<=op_result_i. Then Done if remaining==0,
//     else go to Gather. No timeout.
//   - Done: result_o<=acc, done_o=1 for exactly one cycle, then Idle.
//   - Arithmetic: wraps mod 2^32; mul uses the unit's low 32 bits. No overflow flag.
//   - Latency: done_o fires 2 cycles after the last byte for N=1.
//     For N>=2: last result pulse + 2 cycles.
//   - op_result_valid_i outside WaitRes is ignored.
// TESTING
//   1. add, len=16, words 1,2,3 (LE bytes) -> 2 unit ops; done_o once; result_o=6.
//   2. mul, len=12, words 0x00010000,0x00010000 -> result_o=0x00000000 (wrap).
//   3. add, len=8, word 0xDEADBEEF -> op_valid_o never high; result_o=0xDEADBEEF.
//   4. len=4 -> no bytes consumed (rx_ready_o stays 0); done_o pulses; result_o=0.
//   5. op_ready_i held low 5 cycles -> op_a_o/op_b_o/op_valid_o stable; rx_ready_o=0.
//   6. start_add_i&start_mul_i together -> add; start mid-run ignored;
//      rst_ni low mid-Gather -> all outputs 0, next packet correct.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Folds little-endian 32-bit words from the RX byte stream through a shared add/mul unit
// and reports the final accumulator with a one-cycle done pulse.
module alu_op_sequencer #(
  parameter int datawidth_p = 8,
  parameter int hdr_bytes_p = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_add_i,
  input  logic                   start_mul_i,
  input  logic [15:0]            len_i,
  input  logic [datawidth_p-1:0] rx_data_i,
  input  logic                   rx_valid_i,
  output logic                   rx_ready_o,
  output logic [31:0]            op_a_o,
  output logic [31:0]            op_b_o,
  output logic                   op_mul_o,
  output logic                   op_valid_o,
  input  logic                   op_ready_i,
  input  logic [31:0]            op_result_i,
  input  logic                   op_result_valid_i,
  output logic [31:0]            result_o,
  output logic                   done_o,
  output logic                   busy_o
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StGather  = 3'd1;
  localparam logic [2:0] StIssue   = 3'd2;
  localparam logic [2:0] StWaitRes = 3'd3;
  localparam logic [2:0] StDone    = 3'd4;

  logic [2:0]  r_state;
  logic        r_opMul;
  logic        r_first;
  logic        r_done;
  logic [1:0]  r_byteCnt;
  logic [13:0] r_remaining;
  logic [31:0] r_word;
  logic [31:0] r_acc;
  logic [31:0] r_result;

  logic        w_start;
  logic [15:0] w_payloadLen;
  logic [13:0] w_numOps;
  logic [13:0] w_remDec;
  logic [31:0] w_fullWord;

  // A start is only honoured once the previous done pulse has gone, so busy_o never drops early.
  assign w_start      = (r_state == StIdle) && !r_done && (start_add_i || start_mul_i);
  assign w_payloadLen = len_i - 16'(hdr_bytes_p);
  assign w_numOps     = (len_i < 16'(hdr_bytes_p + 4)) ? '0 : w_payloadLen[15:2];
  assign w_remDec     = r_remaining - 14'd1;
  assign w_fullWord   = {rx_data_i, r_word[23:0]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= StIdle;
      r_opMul     <= 1'b0;
      r_first     <= 1'b0;
      r_done      <= 1'b0;
      r_byteCnt   <= 2'd0;
      r_remaining <= '0;
      r_word      <= '0;
      r_acc       <= '0;
      r_result    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_start) begin
            r_opMul     <= !start_add_i;
            r_remaining <= w_numOps;
            r_first     <= 1'b1;
            r_byteCnt   <= 2'd0;
            if (w_numOps == '0) begin
              r_acc   <= '0;
              r_state <= StDone;
            end else begin
              r_state <= StGather;
            end
          end
        end
        StGather: begin
          if (rx_valid_i) begin
            r_word[{r_byteCnt, 3'b000} +: 8] <= rx_data_i;
            r_byteCnt <= r_byteCnt + 2'd1;
            if (r_byteCnt == 2'd3) begin
              r_remaining <= w_remDec;
              // The first word seeds the accumulator without using the unit.
              if (r_first) begin
                r_acc   <= w_fullWord;
                r_first <= 1'b0;
                if (w_remDec == '0) r_state <= StDone;
              end else begin
                r_state <= StIssue;
              end
            end
          end
        end
        StIssue: begin
          if (op_ready_i) r_state <= StWaitRes;
        end
        StWaitRes: begin
          if (op_result_valid_i) begin
            r_acc   <= op_result_i;
            r_state <= (r_remaining == '0) ? StDone : StGather;
          end
        end
        StDone: begin
          r_result <= r_acc;
          r_done   <= 1'b1;
          r_state  <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign rx_ready_o = (r_state == StGather);
  assign op_valid_o = (r_state == StIssue);
  assign op_a_o     = (r_state == StIssue) ? r_acc : '0;
  assign op_b_o     = (r_state == StIssue) ? r_word : '0;
  assign op_mul_o   = (r_state == StIssue) ? r_opMul : 1'b0;
  assign result_o   = r_result;
  assign done_o     = r_done;
  assign busy_o     = (r_state != StIdle) || r_done;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized bench for alu_op_sequencer; a fold-over-words reference model predicts each result.
module tb_alu_op_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_add_i = 1'b0;
  logic        start_mul_i = 1'b0;
  logic [15:0] len_i = '0;
  logic [7:0]  rx_data_i = '0;
  logic        rx_valid_i = 1'b0;
  logic        rx_ready_o;
  logic [31:0] op_a_o;
  logic [31:0] op_b_o;
  logic        op_mul_o;
  logic        op_valid_o;
  logic        op_ready_i;
  logic [31:0] op_result_i;
  logic        op_result_valid_i;
  logic [31:0] result_o;
  logic        done_o;
  logic        busy_o;

  int checks = 0;
  int fails = 0;

  int cyc = 0;
  int doneCount = 0;
  int opCount = 0;
  int bytesTaken = 0;
  int rxReadySeen = 0;
  int opValidSeen = 0;
  int lastByteCyc = 0;
  int lastResCyc = 0;
  int doneCyc = 0;
  logic [31:0] doneResult = '0;
  logic        doneBusy = 1'b0;
  logic        lastOpMul = 1'b0;
  logic        busyAfter = 1'b0;

  int stallCycles = 0;
  int resDelay = 0;
  int stallErr = 0;
  logic [31:0] capA, capB;
  logic        capMul;

  logic [31:0] words[$];

  alu_op_sequencer dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .start_add_i(start_add_i), .start_mul_i(start_mul_i), .len_i(len_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .op_a_o(op_a_o), .op_b_o(op_b_o), .op_mul_o(op_mul_o), .op_valid_o(op_valid_o),
    .op_ready_i(op_ready_i), .op_result_i(op_result_i), .op_result_valid_i(op_result_valid_i),
    .result_o(result_o), .done_o(done_o), .busy_o(busy_o)
  );

  initial forever #5 clk_i = ~clk_i;

  // Event counters sampled mid-cycle, where every DUT input and output is settled.
  always @(negedge clk_i) begin
    cyc <= cyc + 1;
    if (rx_valid_i && rx_ready_o) begin
      bytesTaken  <= bytesTaken + 1;
      lastByteCyc <= cyc;
    end
    if (rx_ready_o) rxReadySeen <= rxReadySeen + 1;
    if (op_valid_o) opValidSeen <= opValidSeen + 1;
    if (op_valid_o && op_ready_i) begin
      opCount   <= opCount + 1;
      lastOpMul <= op_mul_o;
    end
    if (op_result_valid_i) lastResCyc <= cyc;
    if (done_o) begin
      doneCount  <= doneCount + 1;
      doneCyc    <= cyc;
      doneResult <= result_o;
      doneBusy   <= busy_o;
    end
  end

  // Arithmetic unit stand-in: optional ready stall, then a result pulse after resDelay cycles.
  initial begin
    op_ready_i = 1'b0;
    op_result_valid_i = 1'b0;
    op_result_i = '0;
    forever begin
      @(negedge clk_i);
      if (op_valid_o === 1'b1) begin
        capA = op_a_o;
        capB = op_b_o;
        capMul = op_mul_o;
        for (int s = 0; s < stallCycles; s++) begin
          @(posedge clk_i); #1;
          @(negedge clk_i);
          if (op_a_o !== capA || op_b_o !== capB || op_mul_o !== capMul ||
              op_valid_o !== 1'b1 || rx_ready_o !== 1'b0) stallErr++;
        end
        @(posedge clk_i); #1; op_ready_i = 1'b1;
        @(posedge clk_i); #1; op_ready_i = 1'b0;
        for (int d = 0; d < resDelay; d++) begin
          @(posedge clk_i); #1;
        end
        op_result_i = capMul ? capA * capB : capA + capB;
        op_result_valid_i = 1'b1;
        @(posedge clk_i); #1;
        op_result_valid_i = 1'b0;
        op_result_i = $urandom;
      end
    end
  end

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  function automatic int numOps(input logic [15:0] len);
    return (len < 16'd8) ? 0 : (int'(len) - 4) / 4;
  endfunction

  function automatic logic [31:0] modelFold(input logic isMul, input logic [15:0] len);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < numOps(len); i++) begin
      if (i == 0) acc = words[i];
      else if (isMul) acc = acc * words[i];
      else acc = acc + words[i];
    end
    return acc;
  endfunction

  // Drives one packet: start pulse, payload bytes with random gaps, then waits for done.
  task automatic applyStimulus(input logic sAdd, input logic sMul, input logic [15:0] len,
                               input bit injectStart);
    int budget;
    int startDone;
    logic [31:0] w;
    startDone = doneCount;
    start_add_i = sAdd;
    start_mul_i = sMul;
    len_i = len;
    tick();
    start_add_i = 1'b0;
    start_mul_i = 1'b0;
    len_i = 16'($urandom);
    for (int wi = 0; wi < words.size(); wi++) begin
      for (int k = 0; k < 4; k++) begin
        if (injectStart && wi == 0 && k == 1) begin
          start_mul_i = 1'b1;
          len_i = 16'd4;
          tick();
          start_mul_i = 1'b0;
        end
        repeat ($urandom_range(0, 2)) tick();
        w = words[wi];
        rx_data_i = w[8*k +: 8];
        rx_valid_i = 1'b1;
        budget = 0;
        @(negedge clk_i);
        while (rx_ready_o !== 1'b1 && budget < 200) begin
          tick();
          @(negedge clk_i);
          budget++;
        end
        tick();
        rx_valid_i = 1'b0;
        rx_data_i = 8'($urandom);
      end
    end
    budget = 0;
    while (doneCount == startDone && budget < 300) begin
      @(negedge clk_i);
      budget++;
    end
    busyAfter = busy_o;
    tick();
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    checks++;
    if ({rx_ready_o, op_valid_o, op_mul_o, done_o, busy_o, op_a_o, op_b_o, result_o} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got rdy=%b v=%b m=%b d=%b b=%b a=%h b=%h r=%h, want all 0",
               rx_ready_o, op_valid_o, op_mul_o, done_o, busy_o, op_a_o, op_b_o, result_o);
    end
    tick();
    rst_ni = 1'b1;
    tick();
    @(negedge clk_i);
    checks++;
    if ({rx_ready_o, busy_o, done_o} !== 3'b000) begin
      fails++;
      $display("[TB] FAIL idle_after_reset: got rdy=%b busy=%b done=%b, want 000", rx_ready_o, busy_o, done_o);
    end
    tick();
  endtask

  task automatic test_add_basic();
    int d0, o0;
    logic [31:0] exp;
    words = '{32'd1, 32'd2, 32'd3};
    stallCycles = 0;
    resDelay = 1;
    exp = modelFold(1'b0, 16'd16);
    d0 = doneCount;
    o0 = opCount;
    applyStimulus(1'b1, 1'b0, 16'd16, 1'b0);
    repeat (3) tick();
    checks++;
    if (doneResult !== exp) begin
      fails++; $display("[TB] FAIL add_result: got %h, want %h", doneResult, exp);
    end
    checks++;
    if (doneCount - d0 !== 1) begin
      fails++; $display("[TB] FAIL add_done_count: got %0d, want 1", doneCount - d0);
    end
    checks++;
    if (opCount - o0 !== 2) begin
      fails++; $display("[TB] FAIL add_op_count: got %0d, want 2", opCount - o0);
    end
    checks++;
    if (doneCyc - lastResCyc !== 2) begin
      fails++; $display("[TB] FAIL add_latency: got %0d, want 2", doneCyc - lastResCyc);
    end
    checks++;
    if (doneBusy !== 1'b1 || busyAfter !== 1'b0) begin
      fails++; $display("[TB] FAIL add_busy: got done-cycle %b after %b, want 1 then 0", doneBusy, busyAfter);
    end
  endtask

  task automatic test_mul_wrap();
    int o0;
    words = '{32'h0001_0000, 32'h0001_0000};
    stallCycles = 1;
    resDelay = 0;
    o0 = opCount;
    applyStimulus(1'b0, 1'b1, 16'd12, 1'b0);
    checks++;
    if (doneResult !== 32'h0000_0000) begin
      fails++; $display("[TB] FAIL mul_wrap_result: got %h, want 00000000", doneResult);
    end
    checks++;
    if (opCount - o0 !== 1 || lastOpMul !== 1'b1) begin
      fails++; $display("[TB] FAIL mul_op: got ops %0d mul %b, want 1 and 1", opCount - o0, lastOpMul);
    end
  endtask

  task automatic test_single();
    int v0;
    words = '{32'hDEAD_BEEF};
    v0 = opValidSeen;
    applyStimulus(1'b1, 1'b0, 16'd8, 1'b0);
    checks++;
    if (doneResult !== 32'hDEAD_BEEF) begin
      fails++; $display("[TB] FAIL single_result: got %h, want deadbeef", doneResult);
    end
    checks++;
    if (opValidSeen - v0 !== 0) begin
      fails++; $display("[TB] FAIL single_no_op: got %0d op_valid cycles, want 0", opValidSeen - v0);
    end
    checks++;
    if (doneCyc - lastByteCyc !== 2) begin
      fails++; $display("[TB] FAIL single_latency: got %0d, want 2", doneCyc - lastByteCyc);
    end
  endtask

  task automatic test_len4();
    int d0, b0, r0;
    words.delete();
    d0 = doneCount;
    b0 = bytesTaken;
    r0 = rxReadySeen;
    rx_valid_i = 1'b1;
    applyStimulus(1'b1, 1'b0, 16'd4, 1'b0);
    rx_valid_i = 1'b0;
    checks++;
    if (doneResult !== 32'h0 || doneCount - d0 !== 1) begin
      fails++; $display("[TB] FAIL len4_done: got result %h dones %0d, want 0 and 1", doneResult, doneCount - d0);
    end
    checks++;
    if (bytesTaken - b0 !== 0 || rxReadySeen - r0 !== 0) begin
      fails++; $display("[TB] FAIL len4_no_bytes: got taken %0d ready %0d, want 0 0", bytesTaken - b0, rxReadySeen - r0);
    end
  endtask

  task automatic test_stall();
    int s0, v0;
    words = '{32'h1111_1111, 32'h2222_2222};
    stallCycles = 5;
    resDelay = 2;
    s0 = stallErr;
    v0 = opValidSeen;
    applyStimulus(1'b1, 1'b0, 16'd12, 1'b0);
    stallCycles = 0;
    checks++;
    if (stallErr - s0 !== 0) begin
      fails++; $display("[TB] FAIL stall_stable: got %0d unstable cycles, want 0", stallErr - s0);
    end
    checks++;
    if (opValidSeen - v0 !== 7) begin
      fails++; $display("[TB] FAIL stall_valid_hold: got %0d cycles, want 7", opValidSeen - v0);
    end
    checks++;
    if (doneResult !== 32'h3333_3333) begin
      fails++; $display("[TB] FAIL stall_result: got %h, want 33333333", doneResult);
    end
  endtask

  task automatic test_both_start();
    words = '{32'd3, 32'd5};
    resDelay = 0;
    applyStimulus(1'b1, 1'b1, 16'd12, 1'b0);
    checks++;
    if (doneResult !== 32'd8 || lastOpMul !== 1'b0) begin
      fails++; $display("[TB] FAIL both_start_add: got %h mul %b, want 00000008 mul 0", doneResult, lastOpMul);
    end
  endtask

  task automatic test_start_midrun();
    int d0;
    words = '{32'd10, 32'd20, 32'd30};
    d0 = doneCount;
    applyStimulus(1'b1, 1'b0, 16'd16, 1'b1);
    repeat (4) tick();
    checks++;
    if (doneResult !== 32'd60 || doneCount - d0 !== 1) begin
      fails++; $display("[TB] FAIL midrun_start_ignored: got %h dones %0d, want 0000003c and 1", doneResult, doneCount - d0);
    end
  endtask

  task automatic test_reset_midrun();
    start_add_i = 1'b1;
    len_i = 16'd16;
    tick();
    start_add_i = 1'b0;
    rx_valid_i = 1'b1;
    rx_data_i = 8'hA5;
    tick();
    tick();
    rx_valid_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if ({rx_ready_o, op_valid_o, op_mul_o, done_o, busy_o, op_a_o, op_b_o, result_o} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_midrun_outputs: got rdy=%b busy=%b done=%b r=%h, want all 0",
               rx_ready_o, busy_o, done_o, result_o);
    end
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
    words = '{32'h0000_0007, 32'h0000_0009};
    applyStimulus(1'b0, 1'b1, 16'd12, 1'b0);
    checks++;
    if (doneResult !== 32'd63) begin
      fails++; $display("[TB] FAIL reset_midrun_next: got %h, want 0000003f", doneResult);
    end
  endtask

  task automatic test_random();
    int d0, o0, n;
    logic [15:0] len;
    logic sAdd, sMul, isMul;
    logic [31:0] exp;
    for (int p = 0; p < 20; p++) begin
      len = 16'($urandom_range(0, 40));
      n = numOps(len);
      sAdd = 1'($urandom);
      sMul = 1'($urandom);
      if (!sAdd && !sMul) sMul = 1'b1;
      isMul = sMul && !sAdd;
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
      stallCycles = $urandom_range(0, 3);
      resDelay = $urandom_range(0, 3);
      exp = modelFold(isMul, len);
      d0 = doneCount;
      o0 = opCount;
      applyStimulus(sAdd, sMul, len, 1'b0);
      checks++;
      if (doneResult !== exp || doneCount - d0 !== 1) begin
        fails++;
        $display("[TB] FAIL random_result p%0d len %0d mul %b: got %h dones %0d, want %h and 1",
                 p, len, isMul, doneResult, doneCount - d0, exp);
      end
      checks++;
      if (opCount - o0 !== ((n > 1) ? n - 1 : 0)) begin
        fails++; $display("[TB] FAIL random_ops p%0d: got %0d, want %0d", p, opCount - o0, (n > 1) ? n - 1 : 0);
      end
    end
    stallCycles = 0;
  endtask

  task automatic checkOutput();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_mul_wrap();
    test_single();
    test_len4();
    test_stall();
    test_both_start();
    test_start_midrun();
    test_reset_midrun();
    test_random();
    checkOutput();
    $finish;
  end

endmodule
